// File: rtl/tx_frame_fsm_pkg.sv
// Shared types and constants for the serial frame transmitter.
package tx_frame_fsm_pkg;

    localparam int unsigned DataWidth = 8;
    localparam int unsigned IdxWidth  = 3;

    localparam logic [1:0] ParityNone = 2'b00;
    localparam logic [1:0] ParityOdd  = 2'b01;
    localparam logic [1:0] ParityEven = 2'b10;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop1,
        StStop2
    } state_e;

    // Mode 11 is treated like ParityNone.
    function automatic logic has_parity(input logic [1:0] mode);
        return (mode != ParityNone) && (mode != 2'b11);
    endfunction

    // Odd mode: XNOR-reduce; even mode: XOR-reduce.
    function automatic logic parity_bit(input logic [DataWidth-1:0] data,
                                        input logic [1:0] mode);
        return (mode == ParityOdd) ? ~^data : ^data;
    endfunction

endpackage

// File: rtl/tx_piso.sv
// 8-bit parallel-in serial-out register, LSB shifted out first.
module tx_piso
    import tx_frame_fsm_pkg::*;
(
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 load_i,
    input  logic [DataWidth-1:0] load_data_i,
    input  logic                 shift_i,
    output logic                 serial_o,
    output logic                 serial_next_o
);

    logic [DataWidth-1:0] shift_q;

    // Load takes priority over shift; zero is shifted into the top.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            shift_q <= '0;
        end else if (load_i) begin
            shift_q <= load_data_i;
        end else if (shift_i) begin
            shift_q <= {1'b0, shift_q[DataWidth-1:1]};
        end
    end

    // serial_next_o lets the caller register the upcoming bit on the same edge as the shift.
    assign serial_o      = shift_q[0];
    assign serial_next_o = shift_q[1];

endmodule

// File: rtl/tx_frame_fsm.sv
// UART-style frame transmitter: start, 8 data bits LSB first, optional parity, 1 or 2 stops.
module tx_frame_fsm
    import tx_frame_fsm_pkg::*;
(
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 Send,
    input  logic [DataWidth-1:0] DataIn,
    input  logic [1:0]           ParityType,
    input  logic                 StopBits,
    input  logic                 Tick,
    output logic                 BaudEnable,
    output logic                 DataOut,
    output logic                 Busy,
    output logic                 Done
);

    state_e              state_q, state_d;
    logic [IdxWidth-1:0] idx_q, idx_d;
    logic [1:0]          ptype_q, ptype_d;
    logic                stop2_q, stop2_d;
    logic                parity_q, parity_d;
    logic                data_out_q, data_out_d;
    logic                done_q, done_d;
    logic                accept;
    logic                shift;
    logic                piso_serial;
    logic                piso_serial_next;

    tx_piso u_piso (
        .Clock         (Clock),
        .Reset         (Reset),
        .load_i        (accept),
        .load_data_i   (DataIn),
        .shift_i       (shift),
        .serial_o      (piso_serial),
        .serial_next_o (piso_serial_next)
    );

    // State, captured configuration and registered line/done outputs.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            ptype_q    <= '0;
            stop2_q    <= 1'b0;
            parity_q   <= 1'b0;
            data_out_q <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            ptype_q    <= ptype_d;
            stop2_q    <= stop2_d;
            parity_q   <= parity_d;
            data_out_q <= data_out_d;
            done_q     <= done_d;
        end
    end

    // Next state; the line value is chosen from the state being entered so it is registered.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        ptype_d    = ptype_q;
        stop2_d    = stop2_q;
        parity_d   = parity_q;
        data_out_d = data_out_q;
        done_d     = 1'b0;
        accept     = 1'b0;
        shift      = 1'b0;
        unique case (state_q)
            StIdle: begin
                // Tick is deliberately ignored here.
                if (Send) begin
                    accept     = 1'b1;
                    ptype_d    = ParityType;
                    stop2_d    = StopBits;
                    parity_d   = parity_bit(DataIn, ParityType);
                    state_d    = StStart;
                    data_out_d = 1'b0;
                end
            end
            StStart: begin
                if (Tick) begin
                    state_d    = StData;
                    idx_d      = '0;
                    data_out_d = piso_serial;
                end
            end
            StData: begin
                if (Tick) begin
                    if (idx_q == IdxWidth'(DataWidth - 1)) begin
                        if (has_parity(ptype_q)) begin
                            state_d    = StParity;
                            data_out_d = parity_q;
                        end else begin
                            state_d    = StStop1;
                            data_out_d = 1'b1;
                        end
                    end else begin
                        idx_d      = idx_q + 3'd1;
                        shift      = 1'b1;
                        data_out_d = piso_serial_next;
                    end
                end
            end
            StParity: begin
                if (Tick) begin
                    state_d    = StStop1;
                    data_out_d = 1'b1;
                end
            end
            StStop1: begin
                if (Tick) begin
                    data_out_d = 1'b1;
                    if (stop2_q) begin
                        state_d = StStop2;
                    end else begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end
                end
            end
            StStop2: begin
                if (Tick) begin
                    data_out_d = 1'b1;
                    state_d    = StIdle;
                    done_d     = 1'b1;
                end
            end
            default: begin
                state_d    = StIdle;
                data_out_d = 1'b1;
            end
        endcase
    end

    assign BaudEnable = (state_q != StIdle);
    assign Busy       = (state_q != StIdle);
    assign DataOut    = data_out_q;
    assign Done       = done_q;

endmodule

// File: tb/tb_tx_frame_fsm.sv
// Directed bench for tx_frame_fsm with hand-computed frame images.
module tb_tx_frame_fsm;

    logic       Clock = 1'b0;
    logic       Reset;
    logic       Send;
    logic [7:0] DataIn;
    logic [1:0] ParityType;
    logic       StopBits;
    logic       Tick;
    logic       BaudEnable;
    logic       DataOut;
    logic       Busy;
    logic       Done;

    int checks = 0;
    int errors = 0;

    tx_frame_fsm dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .Send       (Send),
        .DataIn     (DataIn),
        .ParityType (ParityType),
        .StopBits   (StopBits),
        .Tick       (Tick),
        .BaudEnable (BaudEnable),
        .DataOut    (DataOut),
        .Busy       (Busy),
        .Done       (Done)
    );

    always #5 Clock = ~Clock;

    // Accept one frame, then tick with two quiet cycles per bit; bits[i] is the line before tick i.
    task automatic transmit(input logic [7:0] d, input logic [1:0] pt, input logic sb,
                            input int inject_at, input logic hold_send,
                            output logic [11:0] bits, output int nticks,
                            output logic acc_out, output logic acc_busy,
                            output logic acc_baud, output logic hold_ok);
        logic first;
        DataIn = d; ParityType = pt; StopBits = sb; Send = 1'b1;
        @(posedge Clock); #1;
        acc_out = DataOut; acc_busy = Busy; acc_baud = BaudEnable;
        if (!hold_send) Send = 1'b0;
        bits = '1; nticks = 99; hold_ok = 1'b1;
        for (int i = 0; i < 14; i++) begin
            if (i == inject_at) begin
                Send = 1'b1; DataIn = 8'h00; ParityType = 2'b10; StopBits = 1'b1;
            end
            @(posedge Clock); #1;
            first = DataOut;
            @(posedge Clock); #1;
            if (DataOut !== first) hold_ok = 1'b0;
            if (i < 12) bits[i] = DataOut;
            Tick = 1'b1;
            @(posedge Clock); #1;
            Tick = 1'b0;
            if (!hold_send) Send = 1'b0;
            if (Done === 1'b1) begin
                nticks = i + 1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        checks++; if (DataOut !== 1'b1) begin errors++; $display("FAIL reset_dataout got %b want 1", DataOut); end
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", Busy); end
        checks++; if (Done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", Done); end
        checks++; if (BaudEnable !== 1'b0) begin errors++; $display("FAIL reset_baud got %b want 0", BaudEnable); end
    endtask

    task automatic test_no_parity();
        logic [11:0] bits; int n; logic ao, ab, ae, hk;
        transmit(8'h55, 2'b00, 1'b0, -1, 1'b0, bits, n, ao, ab, ae, hk);
        checks++; if (ao !== 1'b0) begin errors++; $display("FAIL accept_dataout got %b want 0", ao); end
        checks++; if (ab !== 1'b1) begin errors++; $display("FAIL accept_busy got %b want 1", ab); end
        checks++; if (ae !== 1'b1) begin errors++; $display("FAIL accept_baud got %b want 1", ae); end
        checks++; if (bits[9:0] !== {1'b1, 8'h55, 1'b0}) begin errors++; $display("FAIL frame_55 got %b want %b", bits[9:0], {1'b1, 8'h55, 1'b0}); end
        checks++; if (n !== 10) begin errors++; $display("FAIL len_55 got %0d want 10", n); end
        checks++; if (hk !== 1'b1) begin errors++; $display("FAIL hold_55 got %b want 1", hk); end
        checks++; if (Busy !== 1'b0 || BaudEnable !== 1'b0) begin errors++; $display("FAIL done_cycle_busy got %b%b want 00", Busy, BaudEnable); end
        @(posedge Clock); #1;
        checks++; if (Done !== 1'b0) begin errors++; $display("FAIL done_pulse_width got %b want 0", Done); end
        checks++; if (DataOut !== 1'b1) begin errors++; $display("FAIL idle_line got %b want 1", DataOut); end
    endtask

    task automatic test_parity();
        logic [11:0] bits; int n; logic ao, ab, ae, hk;
        transmit(8'hA3, 2'b10, 1'b0, -1, 1'b0, bits, n, ao, ab, ae, hk);
        checks++; if (bits[10:0] !== {1'b1, 1'b0, 8'hA3, 1'b0}) begin errors++; $display("FAIL even_A3 got %b want %b", bits[10:0], {1'b1, 1'b0, 8'hA3, 1'b0}); end
        checks++; if (n !== 11) begin errors++; $display("FAIL len_even_A3 got %0d want 11", n); end
        @(posedge Clock); #1;
        transmit(8'hA3, 2'b01, 1'b0, -1, 1'b0, bits, n, ao, ab, ae, hk);
        checks++; if (bits[10:0] !== {1'b1, 1'b1, 8'hA3, 1'b0}) begin errors++; $display("FAIL odd_A3 got %b want %b", bits[10:0], {1'b1, 1'b1, 8'hA3, 1'b0}); end
        checks++; if (n !== 11) begin errors++; $display("FAIL len_odd_A3 got %0d want 11", n); end
        @(posedge Clock); #1;
        transmit(8'hA3, 2'b11, 1'b0, -1, 1'b0, bits, n, ao, ab, ae, hk);
        checks++; if (bits[9:0] !== {1'b1, 8'hA3, 1'b0}) begin errors++; $display("FAIL mode11_A3 got %b want %b", bits[9:0], {1'b1, 8'hA3, 1'b0}); end
        checks++; if (n !== 10) begin errors++; $display("FAIL len_mode11 got %0d want 10", n); end
        @(posedge Clock); #1;
    endtask

    task automatic test_two_stop();
        logic [11:0] bits; int n; logic ao, ab, ae, hk;
        transmit(8'hFF, 2'b00, 1'b1, -1, 1'b0, bits, n, ao, ab, ae, hk);
        checks++; if (bits[10:0] !== {2'b11, 8'hFF, 1'b0}) begin errors++; $display("FAIL stop2_FF got %b want %b", bits[10:0], {2'b11, 8'hFF, 1'b0}); end
        checks++; if (n !== 11) begin errors++; $display("FAIL len_stop2_FF got %0d want 11", n); end
        @(posedge Clock); #1;
        transmit(8'hA3, 2'b10, 1'b1, -1, 1'b0, bits, n, ao, ab, ae, hk);
        checks++; if (bits !== {2'b11, 1'b0, 8'hA3, 1'b0}) begin errors++; $display("FAIL full_A3 got %b want %b", bits, {2'b11, 1'b0, 8'hA3, 1'b0}); end
        checks++; if (n !== 12) begin errors++; $display("FAIL len_full got %0d want 12", n); end
        @(posedge Clock); #1;
    endtask

    task automatic test_ignore_send();
        logic [11:0] bits; int n; logic ao, ab, ae, hk;
        transmit(8'h3C, 2'b00, 1'b0, 3, 1'b0, bits, n, ao, ab, ae, hk);
        checks++; if (bits[9:0] !== {1'b1, 8'h3C, 1'b0}) begin errors++; $display("FAIL frame_3C got %b want %b", bits[9:0], {1'b1, 8'h3C, 1'b0}); end
        checks++; if (n !== 10) begin errors++; $display("FAIL len_3C got %0d want 10", n); end
        repeat (3) @(posedge Clock);
        #1;
        checks++; if (Busy !== 1'b0 || DataOut !== 1'b1) begin errors++; $display("FAIL no_second_frame got busy %b line %b want 0 1", Busy, DataOut); end
    endtask

    task automatic test_tick_in_idle();
        int n;
        Tick = 1'b1;
        @(posedge Clock); #1;
        Tick = 1'b0;
        checks++; if (Busy !== 1'b0 || DataOut !== 1'b1) begin errors++; $display("FAIL idle_tick got busy %b line %b want 0 1", Busy, DataOut); end
        DataIn = 8'h01; ParityType = 2'b00; StopBits = 1'b0; Send = 1'b1; Tick = 1'b1;
        @(posedge Clock); #1;
        Send = 1'b0; Tick = 1'b0;
        checks++; if (Busy !== 1'b1 || DataOut !== 1'b0) begin errors++; $display("FAIL send_tick_accept got busy %b line %b want 1 0", Busy, DataOut); end
        @(posedge Clock); #1;
        checks++; if (DataOut !== 1'b0) begin errors++; $display("FAIL start_held got %b want 0", DataOut); end
        n = 99;
        for (int i = 0; i < 14; i++) begin
            Tick = 1'b1;
            @(posedge Clock); #1;
            Tick = 1'b0;
            if (Done === 1'b1) begin n = i + 1; break; end
            @(posedge Clock); #1;
        end
        checks++; if (n !== 10) begin errors++; $display("FAIL len_after_idle_tick got %0d want 10", n); end
    endtask

    task automatic test_abort();
        logic [11:0] bits; int n; logic ao, ab, ae, hk; logic saw_done;
        DataIn = 8'hA5; ParityType = 2'b00; StopBits = 1'b0; Send = 1'b1;
        @(posedge Clock); #1;
        Send = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge Clock); #1;
            Tick = 1'b1;
            @(posedge Clock); #1;
            Tick = 1'b0;
        end
        checks++; if (DataOut !== 1'b0) begin errors++; $display("FAIL bit4_A5 got %b want 0", DataOut); end
        #2 Reset = 1'b1;
        #1;
        checks++; if (DataOut !== 1'b1 || Busy !== 1'b0 || BaudEnable !== 1'b0) begin errors++; $display("FAIL async_abort got line %b busy %b baud %b want 1 0 0", DataOut, Busy, BaudEnable); end
        saw_done = Done;
        Tick = 1'b1;
        repeat (3) begin
            @(posedge Clock); #1;
            saw_done = saw_done | Done;
        end
        Tick = 1'b0;
        #2 Reset = 1'b0;
        repeat (2) begin
            @(posedge Clock); #1;
            saw_done = saw_done | Done;
        end
        checks++; if (saw_done !== 1'b0) begin errors++; $display("FAIL abort_no_done got %b want 0", saw_done); end
        transmit(8'h96, 2'b10, 1'b0, -1, 1'b0, bits, n, ao, ab, ae, hk);
        checks++; if (bits[10:0] !== {1'b1, 1'b0, 8'h96, 1'b0}) begin errors++; $display("FAIL after_abort got %b want %b", bits[10:0], {1'b1, 1'b0, 8'h96, 1'b0}); end
        checks++; if (n !== 11) begin errors++; $display("FAIL len_after_abort got %0d want 11", n); end
        @(posedge Clock); #1;
    endtask

    task automatic test_back_to_back();
        logic [11:0] bits; int n; logic ao, ab, ae, hk;
        transmit(8'h0F, 2'b00, 1'b0, -1, 1'b1, bits, n, ao, ab, ae, hk);
        checks++; if (bits[9:0] !== {1'b1, 8'h0F, 1'b0}) begin errors++; $display("FAIL b2b_first got %b want %b", bits[9:0], {1'b1, 8'h0F, 1'b0}); end
        checks++; if (n !== 10) begin errors++; $display("FAIL b2b_first_len got %0d want 10", n); end
        checks++; if (Done !== 1'b1 || Busy !== 1'b0) begin errors++; $display("FAIL b2b_done_cycle got done %b busy %b want 1 0", Done, Busy); end
        transmit(8'hF0, 2'b01, 1'b0, -1, 1'b0, bits, n, ao, ab, ae, hk);
        checks++; if (ao !== 1'b0 || ab !== 1'b1) begin errors++; $display("FAIL b2b_start got line %b busy %b want 0 1", ao, ab); end
        checks++; if (bits[10:0] !== {1'b1, 1'b1, 8'hF0, 1'b0}) begin errors++; $display("FAIL b2b_second got %b want %b", bits[10:0], {1'b1, 1'b1, 8'hF0, 1'b0}); end
        checks++; if (n !== 11) begin errors++; $display("FAIL b2b_second_len got %0d want 11", n); end
        @(posedge Clock); #1;
    endtask

    initial begin
        Reset = 1'b1; Send = 1'b0; Tick = 1'b0;
        DataIn = 8'h00; ParityType = 2'b00; StopBits = 1'b0;
        #12;
        test_reset();
        #10 Reset = 1'b0;
        @(posedge Clock); #1;
        test_no_parity();
        test_parity();
        test_two_stop();
        test_ignore_send();
        test_tick_in_idle();
        @(posedge Clock); #1;
        test_abort();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
